multiphase_reciprocal_counter: RTL and testbench

- Next-generation fine-resolution front end for the frequency-measurement IP.
- Takes PHASES retimed samples of the signal under test per clk cycle. The samples come from PHASES equally spaced phase clocks and are already resynchronised into clk.
- Finds every rising edge to 1/PHASES-cycle resolution and performs a reciprocal (edge-gated) measurement. Reports the edge count plus first and last fine timestamps for period = (last_ts-first_ts)/edges.
- Adds what the earlier phase-combining generator lacks: a parametrised phase count, sequential measurement, bubble handling and a result handshake.

---
 rtl/multiphase_reciprocal_counter.sv | 161 ++++++++++++++++
 tb/tb_multiphase_reciprocal_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multiphase_reciprocal_counter.sv
// multiphase_reciprocal_counter: fine-resolution reciprocal counter over PHASES retimed samples per clk.
// Defining MPRC_BUBBLE_FILTER_EN adds a single-sample bubble filter (one extra cycle of latency).
module multiphase_reciprocal_counter #(
  parameter int PHASES = 8,
  parameter int FRAC_W = 3,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PHASES-1:0]         phase_samples,
  input  logic                      start,
  input  logic [CNT_W-1:0]          gate_cycles,
  input  logic [CNT_W-1:0]          timeout_cycles,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [CNT_W-1:0]          res_edges,
  output logic [CNT_W+FRAC_W-1:0]   res_first_ts,
  output logic [CNT_W+FRAC_W-1:0]   res_last_ts,
  output logic                      res_timeout,
  output logic [15:0]               bubble_cnt
);
  localparam int TS_W = CNT_W + FRAC_W;
  typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, REPORT} state_t;
  logic [PHASES-1:0] s1, filt, edge_v, edg;
  logic [PHASES:0] fe;
  logic prev_f;
`ifdef MPRC_BUBBLE_FILTER_EN
  logic [PHASES-1:0] s2;
  logic [PHASES+1:0] ext;
  logic prev_raw, bub;
  // neighbours come from the raw stream, so all corrections in a cycle are simultaneous
  always_comb begin
    ext = {s1[0], s2, prev_raw};
    filt = s2;
    bub = 1'b0;
    for (int k = 0; k < PHASES; k++)
      if (ext[k] == ext[k+2] && ext[k+1] != ext[k]) begin
        filt[k] = ext[k];
        bub = 1'b1;
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      s2 <= '0;
      prev_raw <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      s2 <= s1;
      prev_raw <= s2[PHASES-1];
      if (bub && ~&bubble_cnt) bubble_cnt <= bubble_cnt + 16'd1;
    end
`else
  assign filt = s1;
  assign bubble_cnt = '0;
`endif
  assign fe = {filt, prev_f};
  assign edge_v = fe[PHASES:1] & ~fe[PHASES-1:0];
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      prev_f <= 1'b0;
      edg <= '0;
    end else begin
      s1 <= phase_samples;
      prev_f <= filt[PHASES-1];
      edg <= edge_v;
    end
  logic [FRAC_W:0] n_e;
  logic [FRAC_W-1:0] lo, hi;
  always_comb begin
    n_e = '0;
    lo = '0;
    hi = '0;
    for (int k = PHASES - 1; k >= 0; k--) begin
      n_e = n_e + (FRAC_W+1)'(edg[k]);
      if (edg[k]) lo = FRAC_W'(k);
    end
    for (int k = 0; k < PHASES; k++)
      if (edg[k]) hi = FRAC_W'(k);
  end
  state_t state, state_n;
  logic [CNT_W-1:0] coarse, gcnt, gate_r, tlim;
  logic [CNT_W-1:0] coarse_n, gcnt_n, gate_n, tlim_n, edges_n;
  logic [TS_W-1:0] first_n, last_n;
  logic [CNT_W:0] sum;
  logic to_n, any, tmo_hit;
  assign any = |edg;
  assign tmo_hit = tlim != '0 && coarse + CNT_W'(1) == tlim;
  assign busy = state != IDLE;
  assign res_valid = state == REPORT;
  always_comb begin
    state_n = state;
    coarse_n = coarse;
    gcnt_n = gcnt;
    gate_n = gate_r;
    tlim_n = tlim;
    edges_n = res_edges;
    first_n = res_first_ts;
    last_n = res_last_ts;
    to_n = res_timeout;
    sum = {1'b0, res_edges} + (CNT_W+1)'(n_e);
    case (state)
      IDLE: if (start) begin
        state_n = ARM;
        gate_n = gate_cycles == '0 ? CNT_W'(1) : gate_cycles;
        tlim_n = timeout_cycles;
        coarse_n = '0;
        gcnt_n = '0;
        edges_n = '0;
        first_n = '0;
        last_n = '0;
        to_n = 1'b0;
      end
      ARM: if (any) begin
        first_n = {coarse, lo};
        last_n = {coarse, hi};
        edges_n = CNT_W'(n_e) - CNT_W'(1);
        gcnt_n = CNT_W'(1);
        state_n = gate_r == CNT_W'(1) ? CLOSE : GATE;
      end
      GATE: begin
        edges_n = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        last_n = any ? {coarse, hi} : res_last_ts;
        gcnt_n = gcnt + CNT_W'(1);
        state_n = gcnt + CNT_W'(1) == gate_r ? CLOSE : GATE;
      end
      CLOSE: if (any) begin
        last_n = {coarse, lo};
        edges_n = &res_edges ? res_edges : res_edges + CNT_W'(1);
        state_n = REPORT;
      end
      REPORT: state_n = res_ready ? IDLE : REPORT;
      default: state_n = IDLE;
    endcase
    // a closing edge in the timeout cycle still completes normally
    if (state inside {ARM, GATE, CLOSE}) begin
      coarse_n = coarse + CNT_W'(1);
      if (tmo_hit && state_n != REPORT) begin
        state_n = REPORT;
        to_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {coarse, gcnt, gate_r, tlim, res_edges} <= '0;
      {res_first_ts, res_last_ts, res_timeout} <= '0;
    end else begin
      state <= state_n;
      coarse <= coarse_n;
      gcnt <= gcnt_n;
      gate_r <= gate_n;
      tlim <= tlim_n;
      res_edges <= edges_n;
      res_first_ts <= first_n;
      res_last_ts <= last_n;
      res_timeout <= to_n;
    end
endmodule

// File: tb/tb_multiphase_reciprocal_counter.sv
// tb_multiphase_reciprocal_counter: directed and random measurements against a bit-stream reference model.
module tb_multiphase_reciprocal_counter;
  localparam int P = 8, CW = 32, TW = 35, MAXC = 4000;
`ifdef MPRC_BUBBLE_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic [P-1:0] phase_samples = '0;
  logic [CW-1:0] gate_cycles = '0, timeout_cycles = '0;
  logic busy, res_valid, res_timeout;
  logic [CW-1:0] res_edges;
  logic [TW-1:0] res_first_ts, res_last_ts;
  logic [15:0] bubble_cnt;
  bit bits [MAXC*P];
  int cyc = 0, errors = 0, checks = 0;

  multiphase_reciprocal_counter #(.PHASES(P), .FRAC_W(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .phase_samples(phase_samples), .start(start),
    .gate_cycles(gate_cycles), .timeout_cycles(timeout_cycles), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_edges(res_edges),
    .res_first_ts(res_first_ts), .res_last_ts(res_last_ts),
    .res_timeout(res_timeout), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // stream index c is presented during cycle c and captured at the following clock edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "cycle budget exhausted");
    end
    for (int k = 0; k < P; k++) phase_samples[k] = bits[cyc*P + k];
  endtask

  function automatic bit raw(int i);
    return (i < 0 || i >= MAXC*P) ? 1'b0 : bits[i];
  endfunction

  function automatic bit fb(int i);
`ifdef MPRC_BUBBLE_FILTER_EN
    if (i >= 0 && raw(i-1) == raw(i+1) && raw(i) != raw(i-1)) return raw(i-1);
`endif
    return raw(i);
  endfunction

  function automatic bit is_edge(int i);
    return fb(i) && !fb(i-1);
  endfunction

  function automatic int has_bub(int c);
    for (int k = 0; k < P; k++) if (fb(c*P+k) != raw(c*P+k)) return 1;
    return 0;
  endfunction

  // kind 0: square (period a, first high at b, high length h); 1: random with a% ones; 2: word a per cycle
  task automatic fill(input int c0, input int kind, input int a, input int b, input int h);
    int w;
    w = a;
    for (int r = 0; r < 400*P; r++)
      if (c0*P + r < MAXC*P)
        bits[c0*P + r] = kind == 0 ? (r >= b && (r - b) % a < h) :
                         kind == 1 ? ($urandom_range(0, 99) < a) : w[r % P];
  endtask

  // expected result from the global edge list, coarse 0 starting at stream cycle c0
  task automatic model(input int c0, input int g, input int t, output longint ee, output longint ef,
                       output longint el, output bit eto, output int ecc);
    int base, g1, tl, f0, cl, n, seen;
    base = c0 * P;
    g1 = g == 0 ? 1 : g;
    tl = t == 0 ? 1 << 28 : t * P;
    f0 = -1; cl = -1; n = 0; seen = 0;
    for (int r = 0; r < tl && r < 400*P; r++)
      if (is_edge(base + r)) begin
        if (f0 < 0) begin
          f0 = r;
          seen = r;
        end else if (r < (f0 / P + g1) * P) begin
          n++;
          seen = r;
        end else begin
          cl = r;
          break;
        end
      end
    if (cl >= 0) begin
      ee = n + 1; ef = f0; el = cl; eto = 1'b0; ecc = cl / P;
    end else begin
      ee = n; ef = f0 < 0 ? 0 : f0; el = f0 < 0 ? 0 : seen; eto = 1'b1; ecc = t - 1;
    end
  endtask

  task automatic run(input string tag, input int kind, input int a, input int b, input int h,
                     input int g, input int t, input int hold);
    int c0, n, ecc;
    longint ee, ef, el;
    bit eto;
    c0 = cyc + 3;
    fill(c0, kind, a, b, h);
    while (cyc < c0 + LAT - 1) step();
    model(c0, g, t, ee, ef, el, eto, ecc);
    gate_cycles = g;
    timeout_cycles = t;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!res_valid && n < 200) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(ecc + 1));
    for (int i = 0; i <= hold; i++) begin
      check({tag, "_edges"}, 64'(res_edges), 64'(ee));
      check({tag, "_first"}, 64'(res_first_ts), 64'(ef));
      check({tag, "_last"}, 64'(res_last_ts), 64'(el));
      check({tag, "_timeout"}, 64'(res_timeout), 64'(eto));
      if (i < hold) begin
        start = i % 2 == 0;
        step();
        check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      end
    end
    start = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check({tag, "_idle_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int c0, c1, per, exp_b;
    logic [15:0] b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_edges", 64'(res_edges), 64'd0);
    check("rst_bubble", 64'(bubble_cnt), 64'd0);
    run("sq12", 0, 12, 3, 6, 6, 0, 10);
    run("p2", 0, 2, 1, 1, 1, 0, 0);
    run("zero", 2, 0, 0, 0, 5, 20, 0);
    c0 = cyc + 3;
    fill(c0, 0, 12, 2, 6);
    while (cyc < c0 + LAT - 1) step();
    gate_cycles = 100;
    timeout_cycles = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("gate_busy", 64'(busy), 64'd1);
    phase_samples = '0;
    for (int i = cyc*P; i < (cyc + 6)*P; i++) bits[i] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_edges", 64'(res_edges), 64'd0);
    check("mid_rst_first", 64'(res_first_ts), 64'd0);
    check("mid_rst_last", 64'(res_last_ts), 64'd0);
    check("mid_rst_timeout", 64'(res_timeout), 64'd0);
    check("mid_rst_bubble", 64'(bubble_cnt), 64'd0);
    run("post_rst", 0, 10, 5, 4, 3, 0, 0);
    run("bub", 2, 8, 0, 0, 3, 30, 0);
    b0 = bubble_cnt;
    c1 = cyc;
    repeat (10) step();
    exp_b = 0;
    for (int c = c1 - 2; c < c1 + 8; c++) exp_b += has_bub(c);
    check("bubble_rate", 64'(16'(bubble_cnt - b0)), 64'(exp_b));
    for (int r = 0; r < 6; r++) begin
      per = $urandom_range(3, 40);
      run("rnd_sq", 0, per, $urandom_range(0, 15), $urandom_range(1, per - 1),
          $urandom_range(0, 6), $urandom_range(0, 1) == 1 ? $urandom_range(4, 40) : 0, 0);
    end
    for (int r = 0; r < 2; r++)
      run("rnd_noise", 1, 50, 0, 0, $urandom_range(1, 4), $urandom_range(0, 1) == 1 ? $urandom_range(2, 6) : 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
